// File: rtl/morse_pkg.sv
// Shared Morse definitions for the digit encoder/decoder pair: symbol encoding,
// the 10-entry digit code table, decoder FSM states and a table lookup helper.
package morse_pkg;

  localparam logic SYM_DOT  = 1'b1;
  localparam logic SYM_DASH = 1'b0;

  localparam int unsigned MORSE_LEN = 5;

  // Index is the digit value; bit 4 is the first symbol sent.
  localparam logic [MORSE_LEN-1:0] DIGIT_CODE [10] = '{
    5'b00000, 5'b10000, 5'b11000, 5'b11100, 5'b11110,
    5'b11111, 5'b01111, 5'b00111, 5'b00011, 5'b00001
  };

  typedef enum logic [1:0] {
    IDLE,
    MARK,
    SPACE,
    DISCARD
  } state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] digit;
  } decode_t;

  function automatic decode_t decode_code(input logic [MORSE_LEN-1:0] code);
    decode_t r;
    r = '0;
    for (int unsigned i = 0; i < 10; i++) begin
      if (code == DIGIT_CODE[i]) begin
        r.hit   = 1'b1;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/morse_dur_counter.sv
// Saturating time-unit counter with synchronous clear, plus the duration
// thresholds used to classify marks and detect gaps / stuck keys.
module morse_dur_counter #(
  parameter int unsigned CNT_W          = 4,
  parameter int unsigned DASH_MIN_UNITS = 2,
  parameter int unsigned GAP_UNITS      = 3,
  parameter int unsigned MARK_MAX_UNITS = 7
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr_i,
  input  logic             tick_i,
  output logic [CNT_W-1:0] cnt_o,
  output logic             is_dash_o,
  output logic             gap_hit_o,
  output logic             max_hit_o
);

  logic [CNT_W-1:0] cnt_q;

  // Clear beats tick, so the unit on a state-change cycle is never counted.
  always_ff @(posedge clk) begin
    if (reset || clr_i) begin
      cnt_q <= '0;
    end else if (tick_i && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign cnt_o     = cnt_q;
  assign is_dash_o = (cnt_q >= CNT_W'(DASH_MIN_UNITS));
  // Hits fire on the tick that brings the count up to the threshold.
  assign gap_hit_o = tick_i && (cnt_q == CNT_W'(GAP_UNITS - 1));
  assign max_hit_o = tick_i && (cnt_q == CNT_W'(MARK_MAX_UNITS - 1));

endmodule

// File: rtl/morse_decoder.sv
// Serial Morse digit receiver: times keyed marks/spaces, assembles a 5-symbol
// code and reports the digit or an error. Define MORSE_DEC_SYNC_EN for a 2-flop input synchronizer.
module morse_decoder
  import morse_pkg::*;
#(
  parameter int unsigned DASH_MIN_UNITS = 2,
  parameter int unsigned GAP_UNITS      = 3,
  parameter int unsigned MARK_MAX_UNITS = 7,
  parameter int unsigned CNT_W          = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       key_in,
  output logic [3:0] digit,
  output logic [4:0] symbols,
  output logic       valid,
  output logic       error
);

  logic                 key_s;
  logic                 key_prev_q;
  logic                 rise, fall;
  logic                 cnt_clr;
  logic [CNT_W-1:0]     cnt;
  logic                 is_dash, gap_hit, max_hit;
  logic                 disc_done;
  state_e               state_q;
  logic [2:0]           sym_cnt_q;
  logic [MORSE_LEN-1:0] buf_q;
  logic [3:0]           digit_q;
  logic [4:0]           symbols_q;
  logic                 valid_q, error_q;
  decode_t              dec;

`ifdef MORSE_DEC_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[0], key_in};
    end
  end

  assign key_s = sync_q[1];
`else
  assign key_s = key_in;
`endif

  // Resetting to 1 keeps a key held through reset from looking like a new mark.
  always_ff @(posedge clk) begin
    if (reset) begin
      key_prev_q <= 1'b1;
    end else begin
      key_prev_q <= key_s;
    end
  end

  assign rise      = key_s && !key_prev_q;
  assign fall      = !key_s && key_prev_q;
  assign disc_done = !key_s && !fall && gap_hit;
  assign dec       = decode_code(buf_q);

  // Counter clear mirrors every transition the FSM takes, plus restarts in DISCARD.
  always_comb begin
    cnt_clr = 1'b0;
    unique case (state_q)
      IDLE:    cnt_clr = rise;
      MARK:    cnt_clr = fall || max_hit;
      SPACE:   cnt_clr = rise || gap_hit;
      DISCARD: cnt_clr = rise || fall || disc_done;
      default: cnt_clr = 1'b1;
    endcase
  end

  morse_dur_counter #(
    .CNT_W          (CNT_W),
    .DASH_MIN_UNITS (DASH_MIN_UNITS),
    .GAP_UNITS      (GAP_UNITS),
    .MARK_MAX_UNITS (MARK_MAX_UNITS)
  ) u_dur (
    .clk       (clk),
    .reset     (reset),
    .clr_i     (cnt_clr),
    .tick_i    (tick),
    .cnt_o     (cnt),
    .is_dash_o (is_dash),
    .gap_hit_o (gap_hit),
    .max_hit_o (max_hit)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      sym_cnt_q <= '0;
      buf_q     <= '0;
      digit_q   <= '0;
      symbols_q <= '0;
      valid_q   <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      error_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          buf_q     <= '0;
          sym_cnt_q <= '0;
          if (rise) state_q <= MARK;
        end
        MARK: begin
          if (fall) begin
            if (cnt == '0) begin
              state_q <= (sym_cnt_q != '0) ? SPACE : IDLE;
            end else begin
              buf_q[3'(MORSE_LEN - 1) - sym_cnt_q] <= is_dash ? SYM_DASH : SYM_DOT;
              sym_cnt_q <= sym_cnt_q + 1'b1;
              state_q   <= SPACE;
            end
          end else if (max_hit) begin
            error_q <= 1'b1;
            state_q <= DISCARD;
          end
        end
        SPACE: begin
          if (rise) begin
            if (sym_cnt_q == 3'(MORSE_LEN)) begin
              error_q <= 1'b1;
              state_q <= DISCARD;
            end else begin
              state_q <= MARK;
            end
          end else if (gap_hit) begin
            if ((sym_cnt_q == 3'(MORSE_LEN)) && dec.hit) begin
              valid_q   <= 1'b1;
              digit_q   <= dec.digit;
              symbols_q <= buf_q;
            end else begin
              error_q <= 1'b1;
            end
            state_q <= IDLE;
          end
        end
        DISCARD: begin
          if (disc_done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign digit   = digit_q;
  assign symbols = symbols_q;
  assign valid   = valid_q;
  assign error   = error_q;

endmodule

// File: doc/morse_decoder.md
# morse_decoder

Serial Morse receiver for digits 0–9; the inverse of the binary-to-Morse encoder path. Samples a keyed on/off line against a time-unit strobe, classifies marks as dot or dash by duration, collects up to five symbols, and on an inter-character gap emits the 4-bit binary digit or flags an error. Sits between the keyed-line input pin and the binary display/consumer logic.

## Interface
- DASH_MIN_UNITS, 2: marks lasting at least this many ticks are dashes; shorter marks are dots.
- GAP_UNITS, 3: a space lasting this many ticks ends the character.
- MARK_MAX_UNITS, 7: a mark reaching this many ticks is a stuck key.
- CNT_W, 4: width of the duration counter; must hold MARK_MAX_UNITS.
- clk  in  1  system clock.
- reset  in  1  reset, synchronous, active-high.
- tick  in  1  one-cycle time-unit strobe.
- key_in  in  1  keyed line; 1 = mark (tone on).
- digit  out  4  decoded digit; holds the last valid value.
- symbols  out  5  received code; symbols[4] is the first symbol; 1 = dot, 0 = dash. This matches the encoder's s1..s5 order.
- valid  out  1  one-cycle pulse; digit and symbols are updated.
- error  out  1  one-cycle pulse; the character was malformed and is discarded.

## Operation
- Edge detect on key_s, which is key_in after optional synchronization, against key_prev. key_prev resets to 1, so a key held high through reset release produces no rising edge.
- FSM states are IDLE, MARK, SPACE, and DISCARD.
- The duration counter cnt clears on every state entry. It increments on tick and saturates at all-ones.
- IDLE:
  - Rising edge goes to MARK.
  - Clears the shift buffer and sym_cnt.
- MARK:
  - Falling edge with cnt = 0 is a glitch. The symbol is dropped. Go to SPACE if sym_cnt > 0, else IDLE.
  - Falling edge with cnt > 0: store dot if cnt < DASH_MIN_UNITS, else dash, at position sym_cnt. Then sym_cnt++ and go to SPACE.
  - cnt reaches MARK_MAX_UNITS: pulse error, go to DISCARD.
- SPACE:
  - Rising edge with sym_cnt < 5 goes to MARK.
  - Rising edge with sym_cnt = 5 is an overflow: pulse error, go to DISCARD.
  - cnt reaches GAP_UNITS ends the character. If sym_cnt = 5 and the code matches a digit, pulse valid and load digit and symbols. Otherwise pulse error. Go to IDLE.
- DISCARD:
  - Stays while the key is high.
  - Leaves to IDLE once a space of GAP_UNITS ticks completes. No second error pulse is issued.
- Code table is the standard Morse digit code:
  - 0 = 00000, 1 = 10000, 2 = 11000, 3 = 11100, 4 = 11110.
  - 5 = 11111, 6 = 01111, 7 = 00111, 8 = 00011, 9 = 00001.
  - Any other 5-symbol pattern is an error.
- valid and error are never asserted together.

## Timing
- Reset values:
  - digit = 0, symbols = 0, valid = 0, error = 0.
  - FSM = IDLE, cnt = 0, sym_cnt = 0, key_prev = 1.
- A key edge and a tick in the same cycle: the edge wins. The state changes and cnt clears, and that tick is not counted in either state.
- valid and error are registered. They assert in the cycle after the tick that completes GAP_UNITS, MARK_MAX_UNITS, or the overflow edge.
- Latency from key_in to internal edge detection is 1 cycle without the synchronizer and 3 cycles with it.
- Reset mid-character aborts the character with no valid or error pulse. Outputs return to their reset values.
- tick held high continuously is legal: every cycle counts as one unit.

## Configuration
- MORSE_DEC_SYNC_EN defined: key_in passes through a two-flop synchronizer before edge detection. Both flops reset to 1.
- MORSE_DEC_SYNC_EN undefined: key_in is used directly and must already be synchronous to clk.

## Structure
- Package morse_pkg contains:
  - SYM_DOT = 1 and SYM_DASH = 0.
  - MORSE_LEN = 5.
  - The 10-entry digit code table.
  - The FSM state enum.
  - Encoder and decoder both share the code table.
- Sub-module morse_dur_counter:
  - Saturating tick counter with clear.
  - Threshold compares for DASH_MIN_UNITS, GAP_UNITS, and MARK_MAX_UNITS.

## Test plan
- Digit 7, sent with 1-tick dots, 3-tick dashes, 1-tick intra-gaps, then a 3-tick gap → one valid pulse, digit = 7, symbols = 5'b00111.
- Digits 0, 5, and 9 sent back-to-back → three valid pulses with digit = 0, 5, 9 and symbols = 00000, 11111, 00001. No error pulses.
- Three dots followed by a gap → one error pulse. digit stays at its previous value.
- Pattern 10101 → error pulse; 6 marks in one character → single error, then DISCARD until a 3-tick gap, then the next digit 4 decodes as valid.
- Key held high for 7 ticks → error pulse. Holding it longer produces no further pulses. After release and a 3-tick gap, digit 2 decodes normally.
- Reset asserted after two symbols, with key_in high through reset release → no pulse, no rise detected. After the key drops, digit 1 decodes as valid; the edge-and-tick coincidence case also verifies the tick is discarded.
